// File: rtl/rs_multi_pkg.sv
// rtl/rs_multi_pkg.sv - shared widths and opcode encodings for the reservation station
package rs_multi_pkg;

  localparam int RS_DATA_W = 32;
  localparam int RS_TAG_W  = 4;
  localparam int RS_OP_W   = 6;
  localparam int RS_PC_W   = 32;

  typedef enum logic [RS_OP_W-1:0] {
    OP_NOP = 6'h00,
    OP_ADD = 6'h01,
    OP_SUB = 6'h02,
    OP_AND = 6'h03,
    OP_OR  = 6'h04,
    OP_XOR = 6'h05,
    OP_SLL = 6'h06,
    OP_SRL = 6'h07,
    OP_LD  = 6'h10,
    OP_ST  = 6'h11,
    OP_BEQ = 6'h20
  } rs_op_e;

endpackage

// File: rtl/rs_multi_if.sv
// rtl/rs_multi_if.sv - dispatch, CDB broadcast and issue bundle of the reservation station
interface rs_multi_if
  import rs_multi_pkg::*;
#(
  parameter int N_CDB  = 2,
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int OP_W   = RS_OP_W,
  parameter int PC_W   = RS_PC_W
) ();

  logic                    disp_valid;
  logic                    disp_ready;
  logic [OP_W-1:0]         disp_op;
  logic [DATA_W-1:0]       disp_imm;
  logic [PC_W-1:0]         disp_pc;
  logic [TAG_W-1:0]        disp_tag;
  logic [DATA_W-1:0]       disp_v1;
  logic [DATA_W-1:0]       disp_v2;
  logic [TAG_W-1:0]        disp_q1;
  logic [TAG_W-1:0]        disp_q2;
  logic                    disp_r1;
  logic                    disp_r2;

  logic [N_CDB-1:0]        cdb_valid;
  logic [N_CDB*TAG_W-1:0]  cdb_tag;
  logic [N_CDB*DATA_W-1:0] cdb_data;

  logic                    iss_valid;
  logic                    iss_ready;
  logic [OP_W-1:0]         iss_op;
  logic [DATA_W-1:0]       iss_v1;
  logic [DATA_W-1:0]       iss_v2;
  logic [DATA_W-1:0]       iss_imm;
  logic [PC_W-1:0]         iss_pc;
  logic [TAG_W-1:0]        iss_tag;

  modport slave (
    input  disp_valid, disp_op, disp_imm, disp_pc, disp_tag,
           disp_v1, disp_v2, disp_q1, disp_q2, disp_r1, disp_r2,
    output disp_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    input  iss_ready,
    output iss_valid, iss_op, iss_v1, iss_v2, iss_imm, iss_pc, iss_tag
  );

  modport master (
    output disp_valid, disp_op, disp_imm, disp_pc, disp_tag,
           disp_v1, disp_v2, disp_q1, disp_q2, disp_r1, disp_r2,
    input  disp_ready,
    output cdb_valid, cdb_tag, cdb_data,
    output iss_ready,
    input  iss_valid, iss_op, iss_v1, iss_v2, iss_imm, iss_pc, iss_tag
  );

endinterface

// File: rtl/rs_oldest_pick.sv
// rtl/rs_oldest_pick.sv - grants the oldest ready entry using an age matrix
module rs_oldest_pick #(
  parameter int N = 8
) (
  input  logic [N-1:0]        ready,
  input  logic [N-1:0][N-1:0] age,
  output logic [N-1:0]        grant,
  output logic                found
);

  // age[j][i] set means j was dispatched before i; any older ready entry vetoes i
  always_comb begin
    grant = ready;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (ready[j] && age[j][i]) grant[i] = 1'b0;
      end
    end
  end

  assign found = |ready;

endmodule

// File: rtl/rs_multi.sv
// rtl/rs_multi.sv - out-of-order reservation station with CDB wakeup and oldest-first issue
module rs_multi
  import rs_multi_pkg::*;
#(
  parameter int RS_DEPTH = 8,
  parameter int N_CDB    = 2,
  parameter int DATA_W   = RS_DATA_W,
  parameter int TAG_W    = RS_TAG_W,
  parameter int OP_W     = RS_OP_W,
  parameter int PC_W     = RS_PC_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  rs_multi_if.slave                 bus,
  output logic [$clog2(RS_DEPTH):0] count
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  logic [RS_DEPTH-1:0]               busy, r1, r2;
  logic [OP_W-1:0]                   op   [RS_DEPTH];
  logic [DATA_W-1:0]                 imm  [RS_DEPTH];
  logic [DATA_W-1:0]                 v1   [RS_DEPTH];
  logic [DATA_W-1:0]                 v2   [RS_DEPTH];
  logic [PC_W-1:0]                   pc   [RS_DEPTH];
  logic [TAG_W-1:0]                  tag  [RS_DEPTH];
  logic [TAG_W-1:0]                  q1   [RS_DEPTH];
  logic [TAG_W-1:0]                  q2   [RS_DEPTH];
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age;

  logic [RS_DEPTH-1:0] ready, grant, free_mask, wk1, wk2;
  logic [DATA_W-1:0]   wd1 [RS_DEPTH];
  logic [DATA_W-1:0]   wd2 [RS_DEPTH];
  logic                found, iss_load, iss_fire, disp_fire, dh1, dh2;
  logic [DATA_W-1:0]   dd1, dd2;
  logic [IDX_W-1:0]    disp_idx;

  logic                iss_valid_q;
  logic [OP_W-1:0]     sel_op, iss_op_q;
  logic [DATA_W-1:0]   sel_v1, sel_v2, sel_imm, iss_v1_q, iss_v2_q, iss_imm_q;
  logic [PC_W-1:0]     sel_pc, iss_pc_q;
  logic [TAG_W-1:0]    sel_tag, iss_tag_q;

  // Scanning from the top port down lets the lowest matching port win
  function automatic logic [DATA_W:0] cdb_lookup(
    input logic [N_CDB-1:0]        vld,
    input logic [N_CDB*TAG_W-1:0]  tags,
    input logic [N_CDB*DATA_W-1:0] data,
    input logic [TAG_W-1:0]        t
  );
    logic [DATA_W:0] res;
    res = '0;
    for (int p = N_CDB - 1; p >= 0; p--) begin
      if (vld[p] && tags[p*TAG_W +: TAG_W] == t) res = {1'b1, data[p*DATA_W +: DATA_W]};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      {wk1[i], wd1[i]} = cdb_lookup(bus.cdb_valid, bus.cdb_tag, bus.cdb_data, q1[i]);
      {wk2[i], wd2[i]} = cdb_lookup(bus.cdb_valid, bus.cdb_tag, bus.cdb_data, q2[i]);
    end
    {dh1, dd1} = cdb_lookup(bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.disp_q1);
    {dh2, dd2} = cdb_lookup(bus.cdb_valid, bus.cdb_tag, bus.cdb_data, bus.disp_q2);
  end

  assign ready = busy & r1 & r2;

  rs_oldest_pick #(.N(RS_DEPTH)) u_pick (
    .ready (ready),
    .age   (age),
    .grant (grant),
    .found (found)
  );

  assign bus.disp_ready = (count < CNT_W'(RS_DEPTH));
  assign disp_fire      = bus.disp_valid && bus.disp_ready;
  assign iss_load       = !iss_valid_q || bus.iss_ready;
  assign iss_fire       = iss_load && found;
  assign free_mask      = iss_fire ? grant : '0;

  always_comb begin
    disp_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) disp_idx = IDX_W'(i);
    end
  end

  always_comb begin
    sel_op  = '0;
    sel_v1  = '0;
    sel_v2  = '0;
    sel_imm = '0;
    sel_pc  = '0;
    sel_tag = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) begin
        sel_op  = sel_op  | op[i];
        sel_v1  = sel_v1  | v1[i];
        sel_v2  = sel_v2  | v2[i];
        sel_imm = sel_imm | imm[i];
        sel_pc  = sel_pc  | pc[i];
        sel_tag = sel_tag | tag[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
      r1   <= '0;
      r2   <= '0;
      age  <= '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        op[i]  <= '0;
        imm[i] <= '0;
        v1[i]  <= '0;
        v2[i]  <= '0;
        pc[i]  <= '0;
        tag[i] <= '0;
        q1[i]  <= '0;
        q2[i]  <= '0;
      end
    end else if (flush) begin
      busy <= '0;
      age  <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (busy[i] && !r1[i] && wk1[i]) begin
          r1[i] <= 1'b1;
          v1[i] <= wd1[i];
        end
        if (busy[i] && !r2[i] && wk2[i]) begin
          r2[i] <= 1'b1;
          v2[i] <= wd2[i];
        end
        if (free_mask[i]) busy[i] <= 1'b0;
        for (int j = 0; j < RS_DEPTH; j++) begin
          if (free_mask[i] || free_mask[j]) age[i][j] <= 1'b0;
        end
      end
      if (disp_fire) begin
        busy[disp_idx] <= 1'b1;
        op[disp_idx]   <= bus.disp_op;
        imm[disp_idx]  <= bus.disp_imm;
        pc[disp_idx]   <= bus.disp_pc;
        tag[disp_idx]  <= bus.disp_tag;
        q1[disp_idx]   <= bus.disp_q1;
        q2[disp_idx]   <= bus.disp_q2;
        r1[disp_idx]   <= bus.disp_r1 || dh1;
        r2[disp_idx]   <= bus.disp_r2 || dh2;
        v1[disp_idx]   <= bus.disp_r1 ? bus.disp_v1 : dd1;
        v2[disp_idx]   <= bus.disp_r2 ? bus.disp_v2 : dd2;
        // Every entry still resident after this edge is older than the new one
        for (int j = 0; j < RS_DEPTH; j++) begin
          age[disp_idx][j] <= 1'b0;
          age[j][disp_idx] <= busy[j] && !free_mask[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_v1_q    <= '0;
      iss_v2_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
      iss_tag_q   <= '0;
    end else if (flush) begin
      iss_valid_q <= 1'b0;
    end else if (iss_load) begin
      iss_valid_q <= found;
      if (found) begin
        iss_op_q  <= sel_op;
        iss_v1_q  <= sel_v1;
        iss_v2_q  <= sel_v2;
        iss_imm_q <= sel_imm;
        iss_pc_q  <= sel_pc;
        iss_tag_q <= sel_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(disp_fire) - CNT_W'(iss_fire);
    end
  end

  assign bus.iss_valid = iss_valid_q;
  assign bus.iss_op    = iss_op_q;
  assign bus.iss_v1    = iss_v1_q;
  assign bus.iss_v2    = iss_v2_q;
  assign bus.iss_imm   = iss_imm_q;
  assign bus.iss_pc    = iss_pc_q;
  assign bus.iss_tag   = iss_tag_q;

endmodule

// File: tb/tb_rs_multi.sv
// tb/tb_rs_multi.sv - directed self-checking bench for rs_multi
module tb_rs_multi;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [3:0] count;

  int n_chk  = 0;
  int n_pass = 0;

  rs_multi_if bus ();

  rs_multi dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] t, input logic rr1, input logic [3:0] qq1, input logic [31:0] vv1,
                      input logic rr2, input logic [3:0] qq2, input logic [31:0] vv2);
    bus.disp_valid = 1'b1;
    bus.disp_tag   = t;
    bus.disp_op    = {2'b00, t};
    bus.disp_imm   = {28'h0, t};
    bus.disp_pc    = 32'h1000 + {26'h0, t, 2'b00};
    bus.disp_r1    = rr1;
    bus.disp_q1    = qq1;
    bus.disp_v1    = vv1;
    bus.disp_r2    = rr2;
    bus.disp_q2    = qq2;
    bus.disp_v2    = vv2;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
  endtask

  task automatic cdb_set(input int p, input logic [3:0] t, input logic [31:0] d);
    bus.cdb_valid[p]          = 1'b1;
    bus.cdb_tag[p*4 +: 4]     = t;
    bus.cdb_data[p*32 +: 32]  = d;
  endtask

  task automatic cdb_clear();
    bus.cdb_valid = '0;
    bus.cdb_tag   = '0;
    bus.cdb_data  = '0;
  endtask

  initial begin
    rst            = 1'b0;
    flush          = 1'b0;
    bus.iss_ready  = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_tag   = '0;
    bus.disp_op    = '0;
    bus.disp_imm   = '0;
    bus.disp_pc    = '0;
    bus.disp_r1    = 1'b0;
    bus.disp_r2    = 1'b0;
    bus.disp_q1    = '0;
    bus.disp_q2    = '0;
    bus.disp_v1    = '0;
    bus.disp_v2    = '0;
    cdb_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 0);
    check("rst_disp_ready", 32'(bus.disp_ready), 1);
    check("rst_iss_valid", 32'(bus.iss_valid), 0);
    check("rst_iss_tag", 32'(bus.iss_tag), 0);
    rst = 1'b1;
    tick();

    // three ready ops issue in order, first two cycles after dispatch
    bus.iss_ready = 1'b1;
    disp(4'd1, 1'b1, 4'd0, 32'h11, 1'b1, 4'd0, 32'h21);
    tick();
    check("t1_not_yet", 32'(bus.iss_valid), 0);
    disp(4'd2, 1'b1, 4'd0, 32'h12, 1'b1, 4'd0, 32'h22);
    tick();
    check("t1_first_valid", 32'(bus.iss_valid), 1);
    check("t1_first_tag", 32'(bus.iss_tag), 1);
    check("t1_first_v1", bus.iss_v1, 32'h11);
    check("t1_first_v2", bus.iss_v2, 32'h21);
    check("t1_count_balanced", 32'(count), 1);
    disp(4'd3, 1'b1, 4'd0, 32'h13, 1'b1, 4'd0, 32'h23);
    tick();
    check("t1_second_tag", 32'(bus.iss_tag), 2);
    idle();
    tick();
    check("t1_third_tag", 32'(bus.iss_tag), 3);
    check("t1_third_pc", bus.iss_pc, 32'h100C);
    check("t1_third_imm", bus.iss_imm, 32'h3);
    check("t1_third_op", 32'(bus.iss_op), 3);
    check("t1_count_empty", 32'(count), 0);
    tick();
    check("t1_drained", 32'(bus.iss_valid), 0);

    // a younger ready op overtakes an older op waiting on the CDB
    disp(4'd5, 1'b0, 4'd7, 32'h0, 1'b1, 4'd0, 32'h2);
    tick();
    disp(4'd6, 1'b1, 4'd0, 32'h6, 1'b1, 4'd0, 32'h6);
    tick();
    check("t2_waiting", 32'(bus.iss_valid), 0);
    idle();
    cdb_set(0, 4'd7, 32'hDEAD);
    tick();
    check("t2_young_first", 32'(bus.iss_tag), 6);
    cdb_clear();
    tick();
    check("t2_woken_tag", 32'(bus.iss_tag), 5);
    check("t2_woken_v1", bus.iss_v1, 32'hDEAD);
    check("t2_woken_v2", bus.iss_v2, 32'h2);
    tick();
    check("t2_drained", 32'(bus.iss_valid), 0);

    // fill to capacity, refuse overflow, wake exactly one
    for (int i = 0; i < 8; i++) begin
      disp(4'(8 + i), 1'b0, 4'(i), 32'h0, 1'b1, 4'd0, 32'(i));
      tick();
    end
    check("t3_full_count", 32'(count), 8);
    check("t3_full_ready", 32'(bus.disp_ready), 0);
    disp(4'd0, 1'b1, 4'd0, 32'h77, 1'b1, 4'd0, 32'h77);
    tick();
    check("t3_full_hold", 32'(count), 8);
    idle();
    tick();
    check("t3_overflow_dropped", 32'(bus.iss_valid), 0);
    cdb_set(0, 4'd3, 32'h33);
    tick();
    cdb_clear();
    tick();
    check("t3_wake_tag", 32'(bus.iss_tag), 11);
    check("t3_wake_v1", bus.iss_v1, 32'h33);
    check("t3_after_count", 32'(count), 7);
    check("t3_after_ready", 32'(bus.disp_ready), 1);
    tick();
    check("t3_drained", 32'(bus.iss_valid), 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t3_flush_count", 32'(count), 0);

    // issue output holds under backpressure
    bus.iss_ready = 1'b0;
    disp(4'd1, 1'b1, 4'd0, 32'h101, 1'b1, 4'd0, 32'h0);
    tick();
    disp(4'd2, 1'b1, 4'd0, 32'h102, 1'b1, 4'd0, 32'h0);
    tick();
    idle();
    check("t4_valid", 32'(bus.iss_valid), 1);
    check("t4_tag", 32'(bus.iss_tag), 1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_hold_valid", 32'(bus.iss_valid), 1);
      check("t4_hold_tag", 32'(bus.iss_tag), 1);
      check("t4_hold_v1", bus.iss_v1, 32'h101);
    end
    check("t4_hold_count", 32'(count), 1);
    bus.iss_ready = 1'b1;
    tick();
    check("t4_next_tag", 32'(bus.iss_tag), 2);
    check("t4_next_v1", bus.iss_v1, 32'h102);
    tick();
    check("t4_drained", 32'(bus.iss_valid), 0);

    // same-cycle CDB capture at dispatch, port 1 only matching
    cdb_set(0, 4'd12, 32'h99);
    cdb_set(1, 4'd3, 32'h55);
    disp(4'd4, 1'b1, 4'd0, 32'h1, 1'b0, 4'd3, 32'h0);
    tick();
    idle();
    cdb_clear();
    tick();
    check("t5_disp_wake_valid", 32'(bus.iss_valid), 1);
    check("t5_disp_wake_tag", 32'(bus.iss_tag), 4);
    check("t5_disp_wake_v2", bus.iss_v2, 32'h55);
    check("t5_disp_wake_v1", bus.iss_v1, 32'h1);
    tick();
    // both ports broadcast the same tag: port 0 data wins
    disp(4'd7, 1'b0, 4'd6, 32'h0, 1'b1, 4'd0, 32'h7);
    tick();
    idle();
    cdb_set(0, 4'd6, 32'hA0);
    cdb_set(1, 4'd6, 32'hB0);
    tick();
    cdb_clear();
    tick();
    check("t5_prio_tag", 32'(bus.iss_tag), 7);
    check("t5_prio_v1", bus.iss_v1, 32'hA0);
    tick();
    check("t5_drained", 32'(bus.iss_valid), 0);

    // flush with five resident entries and a held issue
    bus.iss_ready = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      disp(4'(i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'h0);
      tick();
    end
    idle();
    check("t6_pre_count", 32'(count), 5);
    check("t6_pre_valid", 32'(bus.iss_valid), 1);
    check("t6_pre_tag", 32'(bus.iss_tag), 1);
    flush = 1'b1;
    disp(4'd9, 1'b1, 4'd0, 32'h9, 1'b1, 4'd0, 32'h9);
    tick();
    flush = 1'b0;
    idle();
    check("t6_flush_count", 32'(count), 0);
    check("t6_flush_valid", 32'(bus.iss_valid), 0);
    check("t6_flush_ready", 32'(bus.disp_ready), 1);
    tick();
    check("t6_flush_no_disp", 32'(count), 0);
    check("t6_flush_no_issue", 32'(bus.iss_valid), 0);

    // asynchronous reset in the middle of traffic
    for (int i = 1; i <= 3; i++) begin
      disp(4'(i), 1'b1, 4'd0, 32'(i), 1'b1, 4'd0, 32'h0);
      tick();
    end
    check("t7_pre_count", 32'(count), 2);
    disp(4'd4, 1'b1, 4'd0, 32'h4, 1'b1, 4'd0, 32'h4);
    rst = 1'b0;
    #1;
    check("t7_rst_count", 32'(count), 0);
    check("t7_rst_valid", 32'(bus.iss_valid), 0);
    check("t7_rst_tag", 32'(bus.iss_tag), 0);
    check("t7_rst_v1", bus.iss_v1, 32'h0);
    check("t7_rst_ready", 32'(bus.disp_ready), 1);
    tick();
    rst = 1'b1;
    idle();
    bus.iss_ready = 1'b1;
    tick();
    tick();
    check("t7_post_valid", 32'(bus.iss_valid), 0);
    check("t7_post_count", 32'(count), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
